// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown timer: FSM states, display limits, UI modes.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    EXPIRED
  } state_t;

  localparam logic [6:0] SEC_MAX = 7'd59;
  localparam logic [6:0] MIN_MAX = 7'd59;

  localparam logic [3:0] MODE_SET_SEC = 4'b0110;
  localparam logic [3:0] MODE_SET_MIN = 4'b0111;
  localparam logic [3:0] MODE_RUN     = 4'b1000;

  // Presets come from a 7-bit field, so anything above the limit saturates.
  function automatic logic [6:0] clamp_to(input logic [6:0] value, input logic [6:0] limit);
    return (value > limit) ? limit : value;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// One-second prescaler: TICK pulses for one CLK when the count reaches TICK_DIV-1.
module tick_gen #(
  parameter int TICK_DIV = 50000000
) (
  input  logic CLK,
  input  logic RESETN,
  input  logic en,
  input  logic clr,
  output logic TICK
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign TICK = en && !clr && (cnt == LAST);

  // clr wins over en; with en low the count is held, which is how PAUSE resumes mid-second.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= TICK ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/timer_countdown.sv
// Countdown stage: loads clamped MIN_A/SEC_A in IDLE, counts down once per tick, alarms at 00:00.
// Optional TIMER_ALARM_TIMEOUT_EN: the alarm clears itself after ALARM_SEC ticks in EXPIRED.
module timer_countdown
  import timer_pkg::*;
#(
  parameter int TICK_DIV  = 50000000,
  parameter int ALARM_SEC = 10
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic [6:0] MIN_A,
  input  logic [6:0] SEC_A,
  input  logic [3:0] COUNT,
  input  logic       S,
  input  logic       C,
  output logic [6:0] MIN_T,
  output logic [6:0] SEC_T,
  output logic       RUNNING,
  output logic       ALARM
);

  if (TICK_DIV < 2 || ALARM_SEC < 1) begin : g_param_check
    $error("timer_countdown: TICK_DIV must be >= 2 and ALARM_SEC >= 1");
  end

  state_t state;
  logic   s_last, c_last;
  logic   s_en, c_en;
  logic   btn_ok;
  logic   tick;
  logic   prescale_en;
  logic   prescale_clr;
  logic   at_zero;

  assign btn_ok  = (COUNT == MODE_RUN);
  assign at_zero = (MIN_T == 7'd0) && (SEC_T == 7'd0);

  // Button pulses are one cycle wide, one cycle after the rising edge, and only in run mode.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      s_last <= 1'b0;
      c_last <= 1'b0;
      s_en   <= 1'b0;
      c_en   <= 1'b0;
    end else begin
      s_last <= S;
      c_last <= C;
      s_en   <= S & ~s_last & btn_ok;
      c_en   <= C & ~c_last & btn_ok;
    end
  end

`ifdef TIMER_ALARM_TIMEOUT_EN
  localparam int AW = (ALARM_SEC > 1) ? $clog2(ALARM_SEC) : 1;
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_SEC - 1);
  logic [AW-1:0] alarm_cnt;
  assign prescale_en = (state == RUN) || (state == EXPIRED);
`else
  assign prescale_en = (state == RUN);
`endif

  // Holding the prescaler clear in IDLE covers both entry to IDLE and the IDLE->RUN start.
  assign prescale_clr = (state == IDLE);

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .CLK   (CLK),
    .RESETN(RESETN),
    .en    (prescale_en),
    .clr   (prescale_clr),
    .TICK  (tick)
  );

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state   <= IDLE;
      MIN_T   <= 7'd0;
      SEC_T   <= 7'd0;
      RUNNING <= 1'b0;
      ALARM   <= 1'b0;
`ifdef TIMER_ALARM_TIMEOUT_EN
      alarm_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (!c_en && s_en && !at_zero) begin
            state   <= RUN;
            RUNNING <= 1'b1;
          end else begin
            MIN_T <= clamp_to(MIN_A, MIN_MAX);
            SEC_T <= clamp_to(SEC_A, SEC_MAX);
          end
        end

        RUN: begin
          if (c_en) begin
            state   <= IDLE;
            RUNNING <= 1'b0;
          end else if (s_en) begin
            state   <= PAUSE;
            RUNNING <= 1'b0;
          end else if (tick) begin
            if (SEC_T != 7'd0) begin
              SEC_T <= SEC_T - 7'd1;
            end else if (MIN_T != 7'd0) begin
              MIN_T <= MIN_T - 7'd1;
              SEC_T <= SEC_MAX;
            end
            // Expire on the tick that lands on 00:00; the zero case never decrements.
            if ((MIN_T == 7'd0) && (SEC_T <= 7'd1)) begin
              state   <= EXPIRED;
              RUNNING <= 1'b0;
              ALARM   <= 1'b1;
`ifdef TIMER_ALARM_TIMEOUT_EN
              alarm_cnt <= '0;
`endif
            end
          end
        end

        PAUSE: begin
          if (c_en) begin
            state <= IDLE;
          end else if (s_en) begin
            state   <= RUN;
            RUNNING <= 1'b1;
          end
        end

        EXPIRED: begin
          MIN_T <= 7'd0;
          SEC_T <= 7'd0;
          if (c_en || s_en) begin
            state <= IDLE;
            ALARM <= 1'b0;
          end
`ifdef TIMER_ALARM_TIMEOUT_EN
          else if (tick) begin
            if (alarm_cnt == ALARM_LAST) begin
              state <= IDLE;
              ALARM <= 1'b0;
            end else begin
              alarm_cnt <= alarm_cnt + AW'(1);
            end
          end
`endif
        end

        default: begin
          state   <= IDLE;
          RUNNING <= 1'b0;
          ALARM   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/timer_countdown.md
Name: timer_countdown

Overview:
- Countdown stage directly downstream of the timer preset block.
- Consumes preset minutes/seconds (MIN_A, SEC_A, each 0..59) and counts down once per second.
- Supports start/pause/clear and raises ALARM on reaching 00:00.
- Outputs feed the 7-segment display mux and buzzer driver.

Parameters:
- TICK_DIV, 50000000: CLK cycles per 1 s tick. Must be >= 2; the bench uses 4.
- ALARM_SEC, 10: alarm auto-clear time in seconds. Used only with the optional feature.

Ports:
- CLK  in  1  system clock; all logic rising-edge.
- RESETN  in  1  asynchronous, active-low reset.
- MIN_A  in  7  preset minutes from the preset stage.
- SEC_A  in  7  preset seconds from the preset stage.
- COUNT  in  4  UI mode. Buttons are honoured only when COUNT==4'b1000 (run mode).
- S  in  1  start/pause button, level, synchronous to CLK.
- C  in  1  clear button, level, synchronous to CLK.
- MIN_T  out  7  remaining minutes.
- SEC_T  out  7  remaining seconds.
- RUNNING  out  1  high in RUN.
- ALARM  out  1  high in EXPIRED.

Behaviour:
- Reset, async on RESETN low:
  - state=IDLE; MIN_T=0, SEC_T=0; prescaler=0; RUNNING=0, ALARM=0.
  - Edge-detect history registers = 0.
- Button edge detect:
  - S_EN = S & ~S_LAST, registered; same for C_EN.
  - Pulse is 1 cycle wide, 1 cycle after the rising edge.
  - S_EN/C_EN are masked to 0 unless COUNT==4'b1000.
- Prescaler (tick_gen):
  - Counts 0..TICK_DIV-1 in RUN only.
  - TICK is a 1-cycle pulse when count==TICK_DIV-1, then count returns to 0.
  - Held in PAUSE; cleared to 0 on IDLE->RUN and on any entry to IDLE.
- Priority, same cycle: C_EN > S_EN > TICK.
- States:
  - IDLE:
    - Each cycle MIN_T<=min(MIN_A,59) and SEC_T<=min(SEC_A,59). A preset value of 60 is clamped to 59.
    - S_EN with loaded value != 00:00 -> RUN.
    - S_EN with 00:00 is ignored.
    - C_EN: stay in IDLE.
  - RUN:
    - C_EN -> IDLE.
    - S_EN -> PAUSE; a coincident TICK is discarded with no decrement.
    - TICK:
      - SEC_T>0: SEC_T-1.
      - SEC_T==0 and MIN_T>0: MIN_T-1, SEC_T=59.
      - If the post-decrement value is 00:00, next state is EXPIRED.
  - PAUSE:
    - MIN_T/SEC_T frozen.
    - S_EN -> RUN, prescaler resumes from its held value.
    - C_EN -> IDLE.
  - EXPIRED:
    - MIN_T=SEC_T=0, ALARM=1.
    - S_EN or C_EN -> IDLE; ALARM drops the cycle after.
- Outputs are registered. RUNNING and ALARM update in the same cycle as the state register.
- Mode change away from 4'b1000 does not stop counting; it only masks buttons.
- No arithmetic wrap below 00:00 is permitted under any input sequence.

Optional Feature:
- Macro: TIMER_ALARM_TIMEOUT_EN.
- Defined:
  - In EXPIRED the prescaler keeps running.
  - After ALARM_SEC ticks the block returns to IDLE automatically and ALARM clears.
  - Buttons can still clear the alarm earlier.
- Undefined:
  - ALARM holds indefinitely until S_EN or C_EN.
  - Prescaler is idle in EXPIRED.

Decomposition:
- Shared package timer_pkg:
  - state enum {IDLE, RUN, PAUSE, EXPIRED}.
  - SEC_MAX=59, MIN_MAX=59.
  - MODE_SET_SEC=4'b0110, MODE_SET_MIN=4'b0111, MODE_RUN=4'b1000.
- Sub-module tick_gen:
  - Parameter TICK_DIV.
  - Inputs: CLK, RESETN, en, clr.
  - Output: TICK.
- Edge detect and FSM stay in the top module.

Test Plan (TICK_DIV=4, COUNT=4'b1000 unless stated):
- Reset mid-RUN at 01:30: assert RESETN=0 -> MIN_T=0, SEC_T=0, ALARM=0, RUNNING=0 immediately. After release, IDLE loads 01:30 one cycle later.
- Preset 01:00, pulse S: RUNNING=1 two cycles after the S edge. After 4 CLKs -> 00:59. After 59 further ticks -> 00:00 and ALARM=1.
- SEC_A=60, MIN_A=0 in IDLE -> SEC_T=59. Preset 00:00 plus S pulse -> stays in IDLE, RUNNING=0.
- RUN at 00:05:
  - S pulse coincident with TICK -> PAUSE at 00:05 with no decrement.
  - Hold 20 cycles -> unchanged.
  - S again -> resumes; the next tick occurs after the remaining prescaler cycles.
- S and C pulsed in the same cycle during RUN -> IDLE, display reloads the preset. With COUNT=4'b0110, S pulses are ignored.
- EXPIRED:
  - With TIMER_ALARM_TIMEOUT_EN and ALARM_SEC=3: auto-return to IDLE after 12 CLKs, ALARM=0.
  - Without the macro: ALARM stays high for 100 cycles until a C pulse.
